// File: rtl/uncached_axi_bridge_pkg.sv
// Shared types and AXI constants for the uncached load/store bridge.
// States are binary encoded; the constant AXI fields are tied at the top level.
package uncached_axi_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRdAr  = 3'd1,
        StRdR   = 3'd2,
        StWrReq = 3'd3,
        StWrB   = 3'd4,
        StDone  = 3'd5
    } ub_state_e;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] UNCACHED_ID    = 4'd2;

endpackage

// File: rtl/uncached_axi_bridge.sv
// Turns each uncached CPU load/store into one single-beat AXI4 read or write.
// One transaction outstanding; the CPU stalls until the udata_ok pulse.
module uncached_axi_bridge
    import uncached_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = UNCACHED_ID
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        ureq,
    input  logic        uwr,
    input  logic [1:0]  usize,
    input  logic [31:0] uaddr,
    input  logic [31:0] uwdata,
    input  logic [3:0]  uwstrb,
    output logic        uaddr_ok,
    output logic        udata_ok,
    output logic [31:0] urdata,
    output logic        uerr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    ub_state_e   r_state;
    ub_state_e   w_state_d;
    logic        r_live;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_aw_done;
    logic        r_w_done;
    logic        w_aw_done_d;
    logic        w_w_done_d;
    logic        w_unused_rlast;

    // Single-beat bursts make rlast redundant.
    assign w_unused_rlast = rlast;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state   <= StIdle;
            r_live    <= 1'b0;
            r_size    <= 2'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_rdata   <= 32'd0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_live    <= 1'b1;
            r_aw_done <= w_aw_done_d;
            r_w_done  <= w_w_done_d;
            if (uaddr_ok) begin
                r_size  <= usize;
                r_addr  <= uaddr;
                r_wdata <= uwdata;
                r_wstrb <= uwstrb;
            end
            if (r_state == StRdR && rvalid) begin
                r_rdata <= rdata;
                r_err   <= (rresp != AXI_RESP_OKAY);
            end
            if (r_state == StWrB && bvalid) begin
                r_err <= (bresp != AXI_RESP_OKAY);
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_aw_done_d = r_aw_done;
        w_w_done_d  = r_w_done;
        uaddr_ok    = 1'b0;
        udata_ok    = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        unique case (r_state)
            StIdle: begin
                // r_live holds off acceptance until the first clock after reset release.
                uaddr_ok    = ureq & r_live;
                w_aw_done_d = 1'b0;
                w_w_done_d  = 1'b0;
                if (uaddr_ok) begin
                    w_state_d = uwr ? StWrReq : StRdAr;
                end
            end
            StRdAr: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_state_d = StRdR;
                end
            end
            StRdR: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_state_d = StDone;
                end
            end
            StWrReq: begin
                awvalid     = ~r_aw_done;
                wvalid      = ~r_w_done;
                w_aw_done_d = r_aw_done | awready;
                w_w_done_d  = r_w_done | wready;
                if (w_aw_done_d && w_w_done_d) begin
                    w_state_d   = StWrB;
                    w_aw_done_d = 1'b0;
                    w_w_done_d  = 1'b0;
                end
            end
            StWrB: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                udata_ok  = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign arid   = AXI_ID;
    assign araddr = r_addr;
    assign arsize = {1'b0, r_size};
    assign awid   = AXI_ID;
    assign awaddr = r_addr;
    assign awsize = {1'b0, r_size};
    assign wdata  = r_wdata;
    assign wstrb  = r_wstrb;
    assign wlast  = 1'b1;
    assign urdata = r_rdata;
    assign uerr   = r_err;

endmodule

// File: tb/tb_uncached_axi_bridge.sv
// Bench for uncached_axi_bridge: the bench plays CPU and a randomly delayed AXI slave,
// and checks each request maps to exactly one AXI transaction and one completion.
module tb_uncached_axi_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ureq, uwr;
    logic [1:0]  usize;
    logic [31:0] uaddr, uwdata;
    logic [3:0]  uwstrb;
    logic        uaddr_ok, udata_ok, uerr;
    logic [31:0] urdata;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_tests = 0;
    int n_fail  = 0;
    int last_lat, last_a_cnt, last_d_cnt, last_b_cnt;

    always #5 clk = ~clk;

    uncached_axi_bridge dut (
        .cpu_clk_50M(clk),    .cpu_rst_n(rst_n),
        .ureq(ureq),          .uwr(uwr),          .usize(usize),      .uaddr(uaddr),
        .uwdata(uwdata),      .uwstrb(uwstrb),    .uaddr_ok(uaddr_ok), .udata_ok(udata_ok),
        .urdata(urdata),      .uerr(uerr),
        .arid(arid),          .araddr(araddr),    .arsize(arsize),    .arvalid(arvalid),
        .arready(arready),    .rdata(rdata),      .rresp(rresp),      .rlast(rlast),
        .rvalid(rvalid),      .rready(rready),
        .awid(awid),          .awaddr(awaddr),    .awsize(awsize),    .awvalid(awvalid),
        .awready(awready),    .wdata(wdata),      .wstrb(wstrb),      .wlast(wlast),
        .wvalid(wvalid),      .wready(wready),    .bresp(bresp),      .bvalid(bvalid),
        .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One CPU request against a slave that readies each channel after the given delays.
    // For reads a_dly/d_dly are AR/R delays; for writes a_dly/d_dly/b_dly are AW/W/B delays.
    task automatic run_txn(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb, input int a_dly,
                           input int d_dly, input int b_dly, input logic [1:0] resp,
                           input logic [31:0] rd, input bit junk, input string tag);
        int cyc, acc_cyc, done_cyc, viol, a_wait, d_wait, b_wait;
        bit a_hs, d_hs, b_hs, a_sched, d_sched, b_sched, accepted;
        logic [31:0] got_rdata;
        logic        got_err;
        cyc = 0; acc_cyc = -1; done_cyc = -1; viol = 0;
        a_wait = 0; d_wait = 0; b_wait = 0;
        a_hs = 0; d_hs = 0; b_hs = 0; a_sched = 0; d_sched = 0; b_sched = 0; accepted = 0;
        got_rdata = '0; got_err = 1'b0;
        last_a_cnt = 0; last_d_cnt = 0; last_b_cnt = 0; last_lat = -1;
        @(negedge clk);
        ureq = 1'b1; uwr = wr; usize = size; uaddr = addr; uwdata = wd; uwstrb = strb;
        while (done_cyc < 0 && cyc < 200) begin
            if (a_sched) begin a_hs = 1; a_sched = 0; end
            if (d_sched) begin d_hs = 1; d_sched = 0; end
            if (b_sched) begin b_hs = 1; b_sched = 0; last_b_cnt++; end
            if (udata_ok) begin
                if (!accepted || !(wr ? b_hs : d_hs)) viol++;
                done_cyc  = cyc;
                got_rdata = urdata;
                got_err   = uerr;
            end
            if (wr) begin
                if (arvalid || rready) viol++;
                if (awvalid) begin
                    if (a_hs || awaddr !== addr || awsize !== {1'b0, size} || awid !== 4'd2) viol++;
                    last_a_cnt++;
                end else if (last_a_cnt > 0 && !a_hs) viol++;
                if (wvalid) begin
                    if (d_hs || wdata !== wd || wstrb !== strb || wlast !== 1'b1) viol++;
                    last_d_cnt++;
                end else if (last_d_cnt > 0 && !d_hs) viol++;
                if (bready !== (a_hs && d_hs && !b_hs)) viol++;
            end else begin
                if (awvalid || wvalid || bready) viol++;
                if (arvalid) begin
                    if (a_hs || araddr !== addr || arsize !== {1'b0, size} || arid !== 4'd2) viol++;
                    last_a_cnt++;
                end else if (last_a_cnt > 0 && !a_hs) viol++;
                if (rready !== (a_hs && !d_hs)) viol++;
            end
            if (done_cyc >= 0) begin
                ureq = 1'b0;
            end else if (accepted) begin
                ureq = junk; uwr = 1'($urandom); usize = 2'($urandom_range(2));
                uaddr = $urandom; uwdata = $urandom; uwstrb = 4'($urandom);
            end
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rlast = 0;
            if (wr) begin
                if (awvalid && !a_hs) begin
                    if (a_wait == a_dly) begin awready = 1; a_sched = 1; end else a_wait++;
                end
                if (wvalid && !d_hs) begin
                    if (d_wait == d_dly) begin wready = 1; d_sched = 1; end else d_wait++;
                end
                if (a_hs && d_hs && !b_hs) begin
                    if (b_wait == b_dly) begin bvalid = 1; bresp = resp; b_sched = 1; end
                    else b_wait++;
                end
            end else begin
                if (arvalid && !a_hs) begin
                    if (a_wait == a_dly) begin arready = 1; a_sched = 1; end else a_wait++;
                end
                if (a_hs && !d_hs) begin
                    if (d_wait == d_dly) begin
                        rvalid = 1; rdata = rd; rresp = resp; rlast = 1; d_sched = 1;
                    end else d_wait++;
                end
            end
            #1;
            if (!accepted) begin
                if (uaddr_ok) begin accepted = 1; acc_cyc = cyc; end
            end else if (uaddr_ok) viol++;
            @(negedge clk);
            cyc++;
        end
        if (done_cyc < 0) begin
            ureq = 1'b0;
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            last_lat = done_cyc - acc_cyc;
            @(negedge clk);
            if (udata_ok) viol++;
            check({tag, "_proto"}, viol, 0);
            if (!wr) check({tag, "_rdata"}, got_rdata, rd);
            check({tag, "_uerr"}, got_err, {31'd0, resp != 2'b00});
        end
    endtask

    initial begin
        rst_n = 0; ureq = 1; uwr = 0; usize = 0; uaddr = 0; uwdata = 0; uwstrb = 0;
        arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;

        // Reset held with a pending request: everything quiet.
        repeat (3) begin
            @(negedge clk);
            check("reset_ctl", {uaddr_ok, udata_ok, uerr, arvalid, rready, awvalid, wvalid, bready}, 0);
        end
        check("reset_urdata", urdata, 0);
        rst_n = 1;
        #1 check("reset_ok_early", uaddr_ok, 0);
        @(negedge clk);
        check("reset_first_ok", uaddr_ok, 1);
        ureq = 0;
        check("axi_ids", {arid, awid}, 8'h22);

        run_txn(0, 2'd2, 32'h1FD0_F010, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, "load_zw");
        check("load_zw_lat", last_lat, 3);

        // awready after 3 extra cycles keeps awvalid up for 4 cycles; wready immediate.
        run_txn(1, 2'd0, 32'h1FAF_0003, 32'hAB00_0000, 4'b1000, 3, 0, 0, 2'b00, 0, 1, "st_byte");
        check("st_byte_aw_cycles", last_a_cnt, 4);
        check("st_byte_w_cycles", last_d_cnt, 1);
        check("st_byte_b_hs", last_b_cnt, 1);

        run_txn(1, 2'd2, 32'h1FAF_0010, 32'h0123_4567, 4'hF, 0, 0, 0, 2'b00, 0, 0, "st_zw");
        check("st_zw_lat", last_lat, 3);

        run_txn(1, 2'd1, 32'h1FAF_0022, 32'h5A5A_0000, 4'b1100, 1, 2, 1, 2'b10, 0, 0, "st_slverr");
        run_txn(1, 2'd2, 32'h1FAF_0024, 32'h1111_2222, 4'hF, 0, 0, 0, 2'b00, 0, 0, "st_okay");
        run_txn(0, 2'd2, 32'h1FD0_0000, 0, 0, 2, 1, 0, 2'b11, 32'h0BAD_0BAD, 0, "ld_decerr");

        // Asynchronous reset while the bridge waits in the read data phase.
        @(negedge clk);
        ureq = 1; uwr = 0; usize = 2'd2; uaddr = 32'h1FD0_0100;
        #1 check("rst_mid_accept", uaddr_ok, 1);
        @(negedge clk);
        ureq = 0;
        arready = arvalid;
        @(negedge clk);
        arready = 0;
        check("rst_mid_in_rd_r", rready, 1);
        #2 rst_n = 0;
        #1 check("rst_mid_async", {rready, arvalid, udata_ok}, 0);
        @(negedge clk);
        rst_n = 1;
        rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b10;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_stray", {rready, udata_ok, uerr, arvalid}, 0);
        end
        rvalid = 0;
        run_txn(0, 2'd2, 32'h1FD0_0104, 0, 0, 0, 0, 0, 2'b00, 32'hCAFE_F00D, 0, "ld_after_rst");

        for (int i = 0; i < 1000; i++) begin
            run_txn(0, 2'($urandom_range(2)), $urandom, 0, 0, $urandom_range(7),
                    $urandom_range(7), 0, 2'b00, $urandom, 1'($urandom), "rand_ld");
        end
        for (int i = 0; i < 200; i++) begin
            run_txn(1'($urandom), 2'($urandom_range(2)), $urandom, $urandom, 4'($urandom),
                    $urandom_range(5), $urandom_range(5), $urandom_range(5), 2'($urandom),
                    $urandom, 1'($urandom), "rand_mix");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
